// File: rtl/eth_rx_frame_checker.sv
// rtl/eth_rx_frame_checker.sv - receive-side frame length/keep/pattern/MAC checker with statistics
module eth_rx_frame_checker #(
  parameter int DATA_WIDTH       = 64,
  parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
  parameter int USER_WIDTH       = 1,
  parameter int MIN_FRAME_LENGTH = 60,
  parameter int MAX_FRAME_LENGTH = 1514,
  parameter int CHECK_INCR       = 0
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  rx_error_bad_fcs,
  input  logic                  clear,
  output logic                  frame_done,
  output logic [15:0]           frame_len,
  output logic [4:0]            frame_err,
  output logic [31:0]           frame_count,
  output logic [31:0]           good_count,
  output logic [31:0]           bad_count,
  output logic [47:0]           byte_count
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [KEEP_WIDTH-1:0] KEEP_ALL = '1;
  localparam logic [15:0]           MIN_LEN  = 16'(MIN_FRAME_LENGTH);
  localparam logic [15:0]           MAX_LEN  = 16'(MAX_FRAME_LENGTH);

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic                  keep_err_q, keep_err_d;
  logic                  pat_err_q, pat_err_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  done_q, done_d;
  logic [15:0]           flen_q, flen_d;
  logic [4:0]            ferr_q, ferr_d;
  logic [31:0]           frames_q, frames_d;
  logic [31:0]           good_q, good_d;
  logic [31:0]           bad_q, bad_d;
  logic [47:0]           bytes_q, bytes_d;

  logic [16:0]           beat_bytes;
  logic [16:0]           len_sum;
  logic [15:0]           beat_len;
  logic [KEEP_WIDTH-1:0] keep_inc;
  logic                  keep_full;
  logic                  keep_contig;
  logic                  acc_keep;
  logic                  acc_pat;

  // Byte count of the current beat and the running length it produces (saturating).
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + 17'(s_axis_tkeep[i]);
    end
    len_sum  = ((state_q == S_IDLE) ? 17'd0 : {1'b0, len_q}) + beat_bytes;
    beat_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  // Per-beat keep and pattern checks, folded into the flags accumulated so far.
  always_comb begin
    keep_inc    = s_axis_tkeep + KEEP_WIDTH'(1);
    keep_full   = (s_axis_tkeep == KEEP_ALL);
    keep_contig = (s_axis_tkeep != '0) && ((s_axis_tkeep & keep_inc) == '0);
    acc_keep    = ((state_q == S_ACTIVE) && keep_err_q) ||
                  (s_axis_tlast ? !keep_contig : !keep_full);
    acc_pat     = ((state_q == S_ACTIVE) && pat_err_q) ||
                  ((CHECK_INCR != 0) && (state_q == S_ACTIVE) && keep_full &&
                   (s_axis_tdata != prev_q + DATA_WIDTH'(1)));
  end

  // Next state: frame tracking, result capture on tlast, statistics on the done cycle.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    keep_err_d = keep_err_q;
    pat_err_d  = pat_err_q;
    prev_d     = prev_q;
    done_d     = 1'b0;
    flen_d     = flen_q;
    ferr_d     = ferr_q;
    frames_d   = frames_q;
    good_d     = good_q;
    bad_d      = bad_q;
    bytes_d    = bytes_q;

    if (s_axis_tvalid) begin
      len_d      = beat_len;
      keep_err_d = acc_keep;
      pat_err_d  = acc_pat;
      prev_d     = s_axis_tdata;
      if (s_axis_tlast) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        flen_d  = beat_len;
        ferr_d  = {acc_keep, acc_pat, (beat_len > MAX_LEN), (beat_len < MIN_LEN),
                   (s_axis_tuser[0] | rx_error_bad_fcs)};
      end else begin
        state_d = S_ACTIVE;
      end
    end

    // Clear wins over the frame being retired in the same cycle.
    if (clear) begin
      frames_d = '0;
      good_d   = '0;
      bad_d    = '0;
      bytes_d  = '0;
    end else if (done_q) begin
      frames_d = (frames_q == '1) ? frames_q : frames_q + 32'd1;
      if (ferr_q == '0) begin
        good_d = (good_q == '1) ? good_q : good_q + 32'd1;
      end else begin
        bad_d  = (bad_q == '1) ? bad_q : bad_q + 32'd1;
      end
      bytes_d = bytes_q + {32'd0, flen_q};
    end
  end

  // State and result registers; reset drops any partial frame.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      keep_err_q <= 1'b0;
      pat_err_q  <= 1'b0;
      prev_q     <= '0;
      done_q     <= 1'b0;
      flen_q     <= '0;
      ferr_q     <= '0;
      frames_q   <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      bytes_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      keep_err_q <= keep_err_d;
      pat_err_q  <= pat_err_d;
      prev_q     <= prev_d;
      done_q     <= done_d;
      flen_q     <= flen_d;
      ferr_q     <= ferr_d;
      frames_q   <= frames_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      bytes_q    <= bytes_d;
    end
  end

  assign frame_done  = done_q;
  assign frame_len   = flen_q;
  assign frame_err   = ferr_q;
  assign frame_count = frames_q;
  assign good_count  = good_q;
  assign bad_count   = bad_q;
  assign byte_count  = bytes_q;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// tb/tb_eth_rx_frame_checker.sv - directed self-checking bench for eth_rx_frame_checker
module tb_eth_rx_frame_checker;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic        rx_error_bad_fcs;
  logic        clear;
  logic        frame_done;
  logic [15:0] frame_len;
  logic [4:0]  frame_err;
  logic [31:0] frame_count;
  logic [31:0] good_count;
  logic [31:0] bad_count;
  logic [47:0] byte_count;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_frames  = 0;
  logic [31:0] exp_good    = 0;
  logic [31:0] exp_bad     = 0;
  logic [47:0] exp_bytes   = 0;

  always #5 rx_clk = ~rx_clk;

  eth_rx_frame_checker #(
    .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1),
    .MIN_FRAME_LENGTH(60), .MAX_FRAME_LENGTH(1514), .CHECK_INCR(1)
  ) dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .rx_error_bad_fcs(rx_error_bad_fcs),
    .clear(clear), .frame_done(frame_done), .frame_len(frame_len),
    .frame_err(frame_err), .frame_count(frame_count), .good_count(good_count),
    .bad_count(bad_count), .byte_count(byte_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat from a negedge; returns on the following negedge.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic u, input logic f);
    s_axis_tdata     = d;
    s_axis_tkeep     = k;
    s_axis_tlast     = l;
    s_axis_tuser     = u;
    rx_error_bad_fcs = f;
    s_axis_tvalid    = 1'b1;
    @(negedge rx_clk);
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = 1'b0;
    rx_error_bad_fcs = 1'b0;
  endtask

  task automatic full_beats(input int n, input int start, input logic last_on_final);
    for (int i = 0; i < n; i++) send(64'(start + i), 8'hFF, last_on_final && (i == n - 1), 1'b0, 1'b0);
  endtask

  // Called right after the tlast beat: checks the done cycle, then the counter update.
  task automatic expect_frame(input string tag, input logic [15:0] len, input logic [4:0] err);
    chk({tag, "_done"}, frame_done, 1);
    chk({tag, "_len"}, frame_len, len);
    chk({tag, "_err"}, frame_err, err);
    @(negedge rx_clk);
    exp_frames++;
    if (err == 0) exp_good++; else exp_bad++;
    exp_bytes = exp_bytes + 48'(len);
    chk({tag, "_done_drop"}, frame_done, 0);
    chk({tag, "_frames"}, frame_count, exp_frames);
    chk({tag, "_good"}, good_count, exp_good);
    chk({tag, "_bad"}, bad_count, exp_bad);
    chk({tag, "_bytes"}, byte_count, exp_bytes);
  endtask

  initial begin
    rx_rst_n = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = '0; rx_error_bad_fcs = 1'b0; clear = 1'b0;
    repeat (3) @(negedge rx_clk);
    chk("rst_done", frame_done, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_bytes", byte_count, 0);
    rx_rst_n = 1'b1;
    @(negedge rx_clk);

    // Eight incrementing full beats: a clean 64-byte frame, done only after tlast.
    full_beats(7, 1, 1'b0);
    chk("incr_no_early_done", frame_done, 0);
    send(64'd8, 8'hFF, 1'b1, 1'b0, 1'b0);
    expect_frame("incr64", 16'd64, 5'b00000);

    // Single-beat frame is a runt.
    send(64'd100, 8'hFF, 1'b1, 1'b0, 1'b0);
    expect_frame("single", 16'd8, 5'b00010);

    // 68 bytes ending in a half beat with the MAC bad-frame flag.
    full_beats(8, 1, 1'b0);
    send(64'd9, 8'h0F, 1'b1, 1'b1, 1'b0);
    expect_frame("mac_user", 16'd68, 5'b00001);

    // Short non-last beat followed by a broken sequence: keep and pattern errors.
    send(64'd1, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(64'd2, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(64'd3, 8'h7F, 1'b0, 1'b0, 1'b0);
    full_beats(5, 9, 1'b1);
    expect_frame("keep_pat", 16'd63, 5'b11000);

    // Idle gaps mid-frame change nothing; FCS pulse on tlast is a MAC error.
    full_beats(4, 1, 1'b0);
    repeat (3) @(negedge rx_clk);
    full_beats(3, 5, 1'b0);
    send(64'd8, 8'hFF, 1'b1, 1'b0, 1'b1);
    expect_frame("gap_fcs", 16'd64, 5'b00001);

    // Length boundaries: exactly 60 is legal, 59 is a runt, 1520 is a giant.
    full_beats(7, 1, 1'b0);
    send(64'd8, 8'h0F, 1'b1, 1'b0, 1'b0);
    expect_frame("len60", 16'd60, 5'b00000);
    full_beats(7, 1, 1'b0);
    send(64'd8, 8'h07, 1'b1, 1'b0, 1'b0);
    expect_frame("len59", 16'd59, 5'b00010);
    full_beats(190, 1, 1'b1);
    expect_frame("giant", 16'd1520, 5'b00100);

    // Non-contiguous last keep.
    full_beats(7, 1, 1'b0);
    send(64'd8, 8'h05, 1'b1, 1'b0, 1'b0);
    expect_frame("holey_keep", 16'd58, 5'b10010);

    // Back-to-back frames, clear on the first frame's done cycle.
    full_beats(8, 1, 1'b1);
    chk("b2b_a_done", frame_done, 1);
    chk("b2b_a_len", frame_len, 64);
    clear = 1'b1;
    send(64'd1, 8'hFF, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    chk("clear_frames", frame_count, 0);
    chk("clear_good", good_count, 0);
    chk("clear_bad", bad_count, 0);
    chk("clear_bytes", byte_count, 0);
    exp_frames = 0; exp_good = 0; exp_bad = 0; exp_bytes = 0;
    full_beats(7, 2, 1'b1);
    expect_frame("b2b_b", 16'd64, 5'b00000);

    // Reset mid-frame: outputs drop at once, the partial frame never completes.
    full_beats(4, 1, 1'b0);
    rx_rst_n = 1'b0;
    #1;
    chk("midrst_frames", frame_count, 0);
    chk("midrst_good", good_count, 0);
    chk("midrst_bytes", byte_count, 0);
    chk("midrst_len", frame_len, 0);
    chk("midrst_done", frame_done, 0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    repeat (4) @(negedge rx_clk);
    chk("midrst_no_done", frame_done, 0);
    chk("midrst_still_zero", frame_count, 0);
    exp_frames = 0; exp_good = 0; exp_bad = 0; exp_bytes = 0;
    full_beats(8, 1, 1'b1);
    expect_frame("post_rst", 16'd64, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_checker.md
ETH_RX_FRAME_CHECKER -- requirements
Module: eth_rx_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, receive stream data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width; bit 0 = MAC bad-frame flag.
REQ-004 SHALL have parameter MIN_FRAME_LENGTH, default 60, minimum legal byte count (FCS already stripped).
REQ-005 SHALL have parameter MAX_FRAME_LENGTH, default 1514, maximum legal byte count.
REQ-006 SHALL have parameter CHECK_INCR, default 0, enables incrementing-word payload check.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: rx_clk  in  1  receive clock; rx_rst_n  in  1  async active-low reset.
REQ-008 SHALL have s_axis_tdata  in  DATA_WIDTH  MAC receive data.
REQ-009 SHALL have s_axis_tkeep  in  KEEP_WIDTH  byte enables.
REQ-010 SHALL have s_axis_tvalid  in  1  beat valid (no tready; every valid beat is consumed).
REQ-011 SHALL have s_axis_tlast  in  1  last beat of frame.
REQ-012 SHALL have s_axis_tuser  in  USER_WIDTH  per-beat user; bit 0 sampled on tlast beat.
REQ-013 SHALL have rx_error_bad_fcs  in  1  MAC FCS-error pulse, coincident with tlast beat.
REQ-014 SHALL have clear  in  1  synchronous clear of all counters.
REQ-015 SHALL have frame_done  out  1  one-cycle pulse per completed frame.
REQ-016 SHALL have frame_len  out  16  byte length of completed frame, valid with frame_done, held until next.
REQ-017 SHALL have frame_err  out  5  error flags {keep, pattern, giant, runt, mac}, valid with frame_done.
REQ-018 SHALL have frame_count, good_count, bad_count  out  32 each  frame counters.
REQ-019 SHALL have byte_count  out  48  total bytes of all completed frames.

Function
REQ-020 SHALL implement FSM states IDLE and ACTIVE; IDLE->ACTIVE on valid beat without tlast; ACTIVE->IDLE on valid beat with tlast; valid+tlast in IDLE is a single-beat frame, stays IDLE.
REQ-021 SHALL accumulate length as sum of popcount(tkeep) over valid beats, saturating at 16'hFFFF.
REQ-022 SHALL flag keep error if a non-last beat has tkeep != all-ones, or last beat tkeep is zero or not contiguous from bit 0.
REQ-023 SHALL flag runt if final length < MIN_FRAME_LENGTH and giant if > MAX_FRAME_LENGTH.
REQ-024 SHALL flag mac error if s_axis_tuser[0] or rx_error_bad_fcs is high on the tlast beat.
REQ-025 With CHECK_INCR=1, SHALL flag pattern error if any beat after the first with tkeep all-ones has tdata != previous beat tdata + 1 (modulo 2^DATA_WIDTH); partial beats not compared; with CHECK_INCR=0 bit forced 0.
REQ-026 SHALL assert frame_done exactly one cycle after the tlast beat, with frame_len and frame_err registered in that cycle.
REQ-027 SHALL, in the frame_done cycle, increment frame_count, increment good_count if frame_err==0 else bad_count, and add frame_len to byte_count.
REQ-028 SHALL saturate 32-bit counters at all-ones; byte_count SHALL wrap modulo 2^48.
REQ-029 SHALL ignore beats with tvalid low (gaps mid-frame allowed, no length/state change).
REQ-030 clear SHALL zero all counters next edge and take priority over a coincident frame_done increment (that frame not counted); an in-progress frame SHALL be unaffected and counted when it completes.
REQ-031 A tlast beat may be immediately followed by the next frame's first beat; back-to-back frames SHALL both be counted with no lost beat.

Reset
REQ-032 rx_rst_n low SHALL asynchronously force IDLE, frame_done=0, frame_len=0, frame_err=0, all counters=0, length/pattern state cleared.
REQ-033 Reset mid-frame SHALL discard the partial frame; no frame_done for it after release.
REQ-034 Outputs SHALL change only on rx_clk edges after rx_rst_n deasserts.

Verification
REQ-035 8 beats tkeep=FF, tdata 1..8, tlast on 8th, CHECK_INCR=1 -> frame_done one cycle after, frame_len=64, frame_err=0, good_count=1, byte_count=64.
REQ-036 Single beat tkeep=FF tlast=1 -> frame_len=8, frame_err=5'b00010 (runt), bad_count=1.
REQ-037 8 full beats + 9th beat tkeep=0F with tuser[0]=1 -> frame_len=68, frame_err=5'b00001.
REQ-038 Beat 3 tkeep=7F non-last, plus tdata 1,2,3,9,... -> keep and pattern bits set, bad_count increments.
REQ-039 Two 64-byte frames back-to-back with clear asserted on first frame_done cycle -> counters 0 after clear, then frame_count=1, byte_count=64.
REQ-040 rx_rst_n pulsed low after beat 4 of 8 -> all outputs 0 immediately; no frame_done; next full frame counts as frame_count=1.
